// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard types, fwd encodings and width helper
// for the ID-stage hazard detection and forwarding controller.
package hazard_pkg;

  localparam int MAX_REG_BITS = 8;

  localparam int FWD_RF  = 0;
  localparam int FWD_EX  = 1;
  localparam int FWD_MEM = 2;
  localparam int FWD_WB  = 3;

  typedef logic [MAX_REG_BITS-1:0] reg_t;

  typedef struct packed {
    logic valid;
    logic wr_en;
    reg_t dest;
    logic is_load;
  } sb_entry_t;

  function automatic int fw_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_if.sv
// hazard_if: ID-stage request bundle and hazard controller responses.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_if
  import hazard_pkg::*;
#(
  parameter int REG_BITS = 5,
  parameter int DEPTH    = 3,
  parameter int CNT_W    = 16
) ();

  localparam int FW = fw_width(DEPTH);

  logic                id_valid;
  logic [REG_BITS-1:0] id_rs;
  logic [REG_BITS-1:0] id_rt;
  logic                id_uses_rs;
  logic                id_uses_rt;
  logic                id_wr_en;
  logic [REG_BITS-1:0] id_wr_reg;
  logic                id_is_load;
  logic                redirect;

  logic                stall;
  logic                flush;
  logic [FW-1:0]       fwd_a;
  logic [FW-1:0]       fwd_b;
  logic [CNT_W-1:0]    stall_count;
  logic [CNT_W-1:0]    flush_count;

  modport master (
    output id_valid, id_rs, id_rt,
    output id_uses_rs, id_uses_rt,
    output id_wr_en, id_wr_reg,
    output id_is_load, redirect,
    input  stall, flush, fwd_a, fwd_b,
    input  stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt,
    input  id_uses_rs, id_uses_rt,
    input  id_wr_en, id_wr_reg,
    input  id_is_load, redirect,
    output stall, flush, fwd_a, fwd_b,
    output stall_count, flush_count
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: DEPTH-entry shift register of in-flight writers.
// kill_i[k] invalidates whatever lands in entry k on this edge.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  sb_entry_t             ins_i,
  input  logic      [DEPTH:1]   kill_i,
  output sb_entry_t [DEPTH:1]   sb_o
);

  sb_entry_t [DEPTH:1] sb_q, sb_d;

  always_comb begin
    sb_d = sb_q;
    sb_d[1] = ins_i;
    for (int k = 2; k <= DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    for (int k = 1; k <= DEPTH; k++) begin
      if (kill_i[k]) sb_d[k].valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sb_q <= '0;
    else       sb_q <= sb_d;
  end

  assign sb_o = sb_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use stall, redirect flush
// and saturating event counters for the instruction in ID.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_BITS       = 5,
  parameter int DEPTH          = 3,
  parameter int LOAD_LAT       = 1,
  parameter int REDIRECT_STAGE = 2,
  parameter int CNT_W          = 16
) (
  input logic     Clk,
  input logic     Rst,
  hazard_if.slave bus
);

  localparam int FW = fw_width(DEPTH);

  sb_entry_t [DEPTH:1] sb;
  sb_entry_t           ins;
  logic [DEPTH:1]      kill;
  logic [FW-1:0]       sel_a, sel_b;
  logic                blk_a, blk_b;
  logic                stall, flush;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

  function automatic logic hit(
    input sb_entry_t e,
    input logic      uses,
    input reg_t      s
  );
    return uses && (s != '0) && e.valid
        && e.wr_en && (e.dest == s);
  endfunction

  // Scan oldest to youngest so the youngest producer wins.
  always_comb begin
    sel_a = FW'(FWD_RF);
    sel_b = FW'(FWD_RF);
    blk_a = 1'b0;
    blk_b = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (hit(sb[k], bus.id_uses_rs,
              reg_t'(bus.id_rs))) begin
        sel_a = FW'(k);
        blk_a = sb[k].is_load && (k <= LOAD_LAT);
      end
      if (hit(sb[k], bus.id_uses_rt,
              reg_t'(bus.id_rt))) begin
        sel_b = FW'(k);
        blk_b = sb[k].is_load && (k <= LOAD_LAT);
      end
    end
  end

  assign flush = !Rst && bus.redirect;
  assign stall = !Rst && bus.id_valid
              && !bus.redirect && (blk_a || blk_b);

  always_comb begin
    ins         = '0;
    ins.valid   = bus.id_valid && !stall && !flush;
    ins.wr_en   = bus.id_wr_en;
    ins.dest    = reg_t'(bus.id_wr_reg);
    ins.is_load = bus.id_is_load;
    kill        = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      kill[k] = flush && (k <= REDIRECT_STAGE);
    end
  end

  hazard_scoreboard #(
    .DEPTH (DEPTH)
  ) u_sb (
    .clk_i  (Clk),
    .rst_i  (Rst),
    .ins_i  (ins),
    .kill_i (kill),
    .sb_o   (sb)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.flush       = flush;
  assign bus.fwd_a       = Rst ? '0 : sel_a;
  assign bus.fwd_b       = Rst ? '0 : sel_b;
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table, saturation/reset sequence
// and random stimulus checked against an in-flight queue model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int RB    = 5;
  localparam int DEPTH = 3;
  localparam int LLAT  = 1;
  localparam int RSTG  = 2;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  hazard_if #(.REG_BITS(RB), .DEPTH(DEPTH),
              .CNT_W(16)) bus ();
  hazard_if #(.REG_BITS(RB), .DEPTH(DEPTH),
              .CNT_W(4)) bus4 ();

  hazard_ctrl #(
    .REG_BITS(RB), .DEPTH(DEPTH), .LOAD_LAT(LLAT),
    .REDIRECT_STAGE(RSTG), .CNT_W(16)
  ) dut (.Clk(Clk), .Rst(Rst), .bus(bus.slave));

  hazard_ctrl #(
    .REG_BITS(RB), .DEPTH(DEPTH), .LOAD_LAT(LLAT),
    .REDIRECT_STAGE(RSTG), .CNT_W(4)
  ) dut4 (.Clk(Clk), .Rst(Rst), .bus(bus4.slave));

  assign bus4.id_valid   = bus.id_valid;
  assign bus4.id_rs      = bus.id_rs;
  assign bus4.id_rt      = bus.id_rt;
  assign bus4.id_uses_rs = bus.id_uses_rs;
  assign bus4.id_uses_rt = bus.id_uses_rt;
  assign bus4.id_wr_en   = bus.id_wr_en;
  assign bus4.id_wr_reg  = bus.id_wr_reg;
  assign bus4.id_is_load = bus.id_is_load;
  assign bus4.redirect   = bus.redirect;

  typedef struct {
    bit rst, valid, urs, urt, wr, ld, redir;
    int rs, rt, wreg;
  } in_t;

  typedef struct {
    in_t i;
    bit  st, fl;
    int  fa, fb;
  } vec_t;

  typedef struct {
    bit valid, wr, ld;
    int dest;
  } ent_t;

  // pipe[0] is the youngest in-flight instruction (EX).
  ent_t pipe[$];
  int   m_stall_n, m_flush_n;
  int   checks, passes;
  bit   e_st, e_fl;
  int   e_fa, e_fb;

  function automatic vec_t V(
    bit rst, bit valid, int rs, bit urs,
    int rt, bit urt, bit wr, int wreg, bit ld,
    bit redir, bit st, bit fl, int fa, int fb);
    vec_t v;
    v.i.rst = rst;  v.i.valid = valid;
    v.i.rs = rs;    v.i.urs = urs;
    v.i.rt = rt;    v.i.urt = urt;
    v.i.wr = wr;    v.i.wreg = wreg;
    v.i.ld = ld;    v.i.redir = redir;
    v.st = st; v.fl = fl; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  task automatic youngest(input int s, input bit uses,
                          output int sel, output bit blk);
    sel = 0;
    blk = 1'b0;
    if (uses && s != 0) begin
      for (int i = pipe.size() - 1; i >= 0; i--) begin
        if (pipe[i].valid && pipe[i].wr
            && pipe[i].dest == s) begin
          sel = i + 1;
          blk = pipe[i].ld && (sel <= LLAT);
        end
      end
    end
  endtask

  task automatic model_reset();
    ent_t b;
    b = '{valid: 1'b0, wr: 1'b0, ld: 1'b0, dest: 0};
    pipe = {};
    repeat (DEPTH) pipe.push_back(b);
    m_stall_n = 0;
    m_flush_n = 0;
  endtask

  task automatic apply(input in_t x);
    int  sa, sb;
    bit  ba, bb;
    ent_t n;
    @(negedge Clk);
    Rst            = x.rst;
    bus.id_valid   = x.valid;
    bus.id_rs      = RB'(x.rs);
    bus.id_rt      = RB'(x.rt);
    bus.id_uses_rs = x.urs;
    bus.id_uses_rt = x.urt;
    bus.id_wr_en   = x.wr;
    bus.id_wr_reg  = RB'(x.wreg);
    bus.id_is_load = x.ld;
    bus.redirect   = x.redir;
    #1;
    youngest(x.rs, x.urs, sa, ba);
    youngest(x.rt, x.urt, sb, bb);
    e_fl = !x.rst && x.redir;
    e_st = !x.rst && x.valid && !x.redir && (ba || bb);
    e_fa = x.rst ? 0 : sa;
    e_fb = x.rst ? 0 : sb;
    chk("stall", int'(bus.stall), int'(e_st));
    chk("flush", int'(bus.flush), int'(e_fl));
    chk("fwd_a", int'(bus.fwd_a), e_fa);
    chk("fwd_b", int'(bus.fwd_b), e_fb);
    chk("stall_count", int'(bus.stall_count),
        sat(m_stall_n, 16));
    chk("flush_count", int'(bus.flush_count),
        sat(m_flush_n, 16));
    chk("stall_w4", int'(bus4.stall), int'(e_st));
    chk("fwd_a_w4", int'(bus4.fwd_a), e_fa);
    chk("stall_count_w4", int'(bus4.stall_count),
        sat(m_stall_n, 4));
    chk("flush_count_w4", int'(bus4.flush_count),
        sat(m_flush_n, 4));
    if (x.rst) begin
      model_reset();
    end else begin
      n = '{valid: 1'b0, wr: 1'b0, ld: 1'b0, dest: 0};
      if (x.valid && !e_st && !e_fl)
        n = '{valid: 1'b1, wr: x.wr, ld: x.ld,
              dest: x.wreg};
      if (e_fl)
        for (int i = 0; i < RSTG - 1; i++)
          pipe[i].valid = 1'b0;
      pipe.push_front(n);
      void'(pipe.pop_back());
      m_stall_n += int'(e_st);
      m_flush_n += int'(e_fl);
    end
  endtask

  vec_t tbl[$];
  vec_t idle;
  vec_t lw3, use3;
  in_t  r;

  initial begin
    checks = 0;
    passes = 0;
    model_reset();
    bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0;
    bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.id_wr_en = 0; bus.id_wr_reg = '0;
    bus.id_is_load = 0; bus.redirect = 0;
    repeat (2) @(posedge Clk);

    //        rst v  rs u  rt u  wr wreg ld rd st fl fa fb
    tbl.push_back(V(1,1, 3,1, 3,1, 1, 4, 0,0, 0,0,0,0));
    tbl.push_back(V(0,1, 1,1, 2,1, 1, 3, 0,0, 0,0,0,0));
    tbl.push_back(V(0,1, 3,1, 5,1, 1, 4, 0,0, 0,0,1,0));
    tbl.push_back(V(0,1, 4,1, 0,0, 1, 3, 1,0, 0,0,1,0));
    tbl.push_back(V(0,1, 3,1, 3,1, 1, 4, 0,0, 1,0,1,1));
    tbl.push_back(V(0,1, 3,1, 3,1, 1, 4, 0,0, 0,0,2,2));
    tbl.push_back(V(0,1, 0,1, 0,0, 1, 3, 1,0, 0,0,0,0));
    tbl.push_back(V(0,1, 7,1, 8,1, 1, 3, 0,0, 0,0,0,0));
    tbl.push_back(V(0,1, 3,1, 9,1, 1, 6, 0,0, 0,0,1,0));
    tbl.push_back(V(0,1, 1,1, 2,1, 0, 0, 0,0, 0,0,0,0));
    tbl.push_back(V(0,1, 0,1, 0,0, 1,10, 1,0, 0,0,0,0));
    tbl.push_back(V(0,1,10,1,10,1, 1,11, 0,1, 0,1,1,1));
    tbl.push_back(V(0,1,10,1,10,1, 1,11, 0,0, 0,0,0,0));
    tbl.push_back(V(0,1, 0,0, 0,0, 0, 0, 0,1, 0,1,0,0));
    tbl.push_back(V(0,1, 0,0, 0,0, 0, 0, 0,1, 0,1,0,0));
    tbl.push_back(V(0,1, 1,1, 2,1, 1, 0, 0,0, 0,0,0,0));
    tbl.push_back(V(0,1, 0,1, 0,1, 1, 5, 0,0, 0,0,0,0));
    tbl.push_back(V(0,1, 0,1, 0,0, 1, 0, 1,0, 0,0,0,0));
    tbl.push_back(V(0,1, 0,1, 0,1, 1, 7, 0,0, 0,0,0,0));
    tbl.push_back(V(0,1, 0,1, 0,0, 1, 3, 1,0, 0,0,0,0));
    tbl.push_back(V(1,1, 3,1, 3,1, 1, 4, 0,0, 0,0,0,0));

    foreach (tbl[i]) begin
      apply(tbl[i].i);
      chk($sformatf("tbl%0d_stall", i),
          int'(bus.stall), int'(tbl[i].st));
      chk($sformatf("tbl%0d_flush", i),
          int'(bus.flush), int'(tbl[i].fl));
      chk($sformatf("tbl%0d_fwd_a", i),
          int'(bus.fwd_a), tbl[i].fa);
      chk($sformatf("tbl%0d_fwd_b", i),
          int'(bus.fwd_b), tbl[i].fb);
      if (i == 5)
        chk("lu_stall_count", int'(bus.stall_count), 1);
      if (i == 12)
        chk("br_flush_count", int'(bus.flush_count), 1);
      if (i == 15)
        chk("redir_b2b_count", int'(bus.flush_count), 3);
    end

    idle = V(0,0, 0,0, 0,0, 0, 0, 0,0, 0,0,0,0);
    apply(idle.i);
    chk("post_rst_stall_cnt", int'(bus.stall_count), 0);
    chk("post_rst_flush_cnt", int'(bus.flush_count), 0);

    lw3  = V(0,1, 0,1, 0,0, 1, 3, 1,0, 0,0,0,0);
    use3 = V(0,1, 3,1, 3,1, 1, 4, 0,0, 0,0,0,0);
    for (int n = 0; n < 20; n++) begin
      apply(lw3.i);
      apply(use3.i);
      chk("sat_seq_stall", int'(bus.stall), 1);
      apply(use3.i);
    end
    apply(idle.i);
    chk("sat_cnt_w4", int'(bus4.stall_count), 15);
    chk("cnt_w16", int'(bus.stall_count), 20);

    apply(lw3.i);
    use3.i.rst = 1'b1;
    apply(use3.i);
    chk("rst_stall", int'(bus.stall), 0);
    chk("rst_fwd_a", int'(bus.fwd_a), 0);
    apply(idle.i);
    chk("rst_cnt_w4", int'(bus4.stall_count), 0);
    chk("rst_cnt_w16", int'(bus.stall_count), 0);

    for (int n = 0; n < 600; n++) begin
      r.rst   = ($urandom_range(63) == 0);
      r.valid = ($urandom_range(7) != 0);
      r.rs    = int'($urandom_range(7));
      r.rt    = int'($urandom_range(7));
      r.urs   = ($urandom_range(3) != 0);
      r.urt   = ($urandom_range(1) != 0);
      r.wr    = ($urandom_range(3) != 0);
      r.wreg  = int'($urandom_range(7));
      r.ld    = ($urandom_range(2) == 0);
      r.redir = ($urandom_range(7) == 0);
      apply(r);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard detection and forwarding controller for the five-stage MIPS pipeline. It sits beside the ID stage. It keeps a scoreboard of in-flight register writers in EX and later stages and produces four things: forwarding selects for the instruction in ID, a load-use stall, a control-hazard flush, and saturating event counters. It lets the pipeline run dependent code without software NOPs. Depth, load latency and redirect stage are parameters, so the same block serves deeper pipeline variants.

## Interface
- REG_BITS, 5, register specifier width
- DEPTH, 3, scoreboard entries tracked (entry 1 = EX, 2 = MEM, 3 = WB)
- LOAD_LAT, 1, a load in entries 1..LOAD_LAT cannot yet forward its data
- REDIRECT_STAGE, 2, entry holding the branch/jump when redirect is asserted (2 = MEM)
- CNT_W, 16, event counter width
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_BITS  source specifiers
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_wr_en  in  1  instruction writes a register
- id_wr_reg  in  REG_BITS  final destination (after RegDst/ra selection)
- id_is_load  in  1  instruction is a load
- redirect  in  1  taken branch/jump/jr resolved this cycle
- stall  out  1  hold PC and IF/ID, inject bubble into ID/EX
- flush  out  1  kill IF/ID and younger in-flight entries
- fwd_a, fwd_b  out  FW = clog2(DEPTH+1)  0 = register file, k = producer in entry k
- stall_count, flush_count  out  CNT_W  saturating event counts

## Operation
- Scoreboard entry fields: valid, wr_en, dest, is_load. Entries 1..DEPTH.
- Each cycle the scoreboard shifts: entry k moves to entry k+1, and entry DEPTH is discarded.
- Entry 1 is loaded from the ID fields when id_valid=1 and stall=0 and flush=0. Otherwise entry 1 is loaded invalid (a bubble).
- Match on source s in entry k requires all of: the source's uses flag is set, s != 0, entry valid, entry wr_en, and dest == s.
- fwd_a/fwd_b select the lowest matching k (youngest producer wins). With no match, the select is 0.
- The datapath registers the select into ID/EX. The producer is then at entry k+1 relative to the consumer in EX.
- stall = id_valid & !redirect & (some used source's youngest match is at k <= LOAD_LAT with is_load set).
- Only the youngest match decides the stall. An older load shadowed by a younger ALU writer does not stall.
- flush = redirect.
  - Entries 1..REDIRECT_STAGE-1 are invalidated during the shift.
  - The ID instruction is not inserted.
  - Redirect has priority over stall.
- stall_count increments on each cycle with stall=1. flush_count increments on each cycle with flush=1. Both saturate at all-ones.

## Timing
- stall, flush, fwd_a and fwd_b are combinational from the current scoreboard and inputs. There are no registered outputs, so there is zero latency.
- Scoreboard and counters update on the Clk edge only.
- Load-use with the default parameters produces exactly one stall cycle, followed by fwd=2 (MEM/WB path).
- Simultaneous redirect and stall condition: flush=1, stall=0, stall_count unchanged.
- Back-to-back redirects: each cycle flushes independently and each is counted.
- Rst=1:
  - All entries are invalid on the next edge and both counters are 0.
  - stall, flush, fwd_a and fwd_b are forced to 0 while Rst=1.
  - Reset mid-stall drops the stall immediately.
- Writes to $0 never forward and never stall.

## Structure
- Shared package hazard_pkg holds:
  - the scoreboard entry struct;
  - the FW width function;
  - the fwd encoding constants FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3.
- One sub-module, hazard_scoreboard: a DEPTH-entry shift register with an insert port and an invalidate mask.
- Match, priority, stall/flush logic and counters stay in hazard_ctrl.

## Test plan
- add $3 then add $4,$3,$5 back-to-back -> fwd_a=1, stall=0, no bubble.
- lw $3 then add $4,$3,$3 -> one cycle with stall=1 and fwd_a=fwd_b=1 blocked, then fwd_a=fwd_b=2, stall_count=1.
- lw $3 followed by add $3 then sub $6,$3 -> youngest match is the add at entry 1, giving fwd_a=1 and stall=0.
- beq taken, redirect asserted while branch is in entry 2 with a load-use pending in ID -> flush=1, stall=0, entry 1 invalidated, flush_count=1.
- Write to $0 followed by a reader of $0 -> fwd_a=0, stall=0.
- CNT_W=4 with 20 stall cycles -> stall_count holds at 15. Then assert Rst for one cycle -> both counters and all outputs read 0.
